hazard_scoreboard: RTL
======================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter NREG, default 8: number of register-file entries.
REQ-002 Parameter AW, default 3: register address width; NREG SHALL equal 2**AW.
REQ-003 Parameter STALL_LIMIT, default 15: consecutive stall cycles before deadlock_err.
REQ-004 clock  in  1  single clock; all state updates on the rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 instv  in  1  instruction presented for issue this cycle.
REQ-007 src1, src2  in  AW each  source register addresses.
REQ-008 src1_rd, src2_rd  in  1 each  source operand is actually read.
REQ-009 dst  in  AW  destination register of the presented instruction.
REQ-010 wr_en  in  1  presented instruction writes dst.
REQ-011 wb_wr_en, wb_dst  in  1, AW  write-back stage commits to wb_dst this cycle.
REQ-012 issue  out  1  presented instruction accepted this cycle.
REQ-013 stall  out  1  presented instruction held; the decode stage re-presents it.
REQ-014 busy_map  out  NREG  bit i set when pend[i] is non-zero.
REQ-015 stall_cnt  out  16  total stall cycles since reset.
REQ-016 deadlock_err  out  1  sticky watchdog flag.

Function
REQ-017 The block SHALL keep a 2-bit pending counter pend[i] for each register.
REQ-018 Hazard SHALL be (src1_rd & pend[src1]!=0) | (src2_rd & pend[src2]!=0) | (wr_en & pend[dst]==3), using only registered counters, with no same-cycle write-back bypass.
REQ-019 FSM states are FLUSH, RUN and STALL; reset SHALL enter FLUSH.
REQ-020 FLUSH SHALL last exactly 2 cycles, then go to RUN; in FLUSH, issue=0 and stall=instv.
REQ-021 In RUN or STALL, issue=instv&~hazard and stall=instv&hazard, both combinational in the same cycle.
REQ-022 From RUN, the FSM SHALL go to STALL when stall=1, and stay in RUN otherwise.
REQ-023 From STALL, the FSM SHALL go to RUN when stall=0, and stay in STALL otherwise.
REQ-024 On issue&wr_en, pend[dst] SHALL increment; on wb_wr_en, pend[wb_dst] SHALL decrement.
REQ-025 If both events target the same register in one cycle, that counter SHALL be unchanged.
REQ-026 wb_wr_en to a register whose pend is 0 SHALL leave it at 0, with no underflow.
REQ-027 Increment at pend=3 is impossible by REQ-018; the counter SHALL never wrap.
REQ-028 stall_cnt SHALL increment on each cycle with stall=1 and saturate at 0xFFFF.
REQ-029 A stall-run counter SHALL count consecutive STALL-state cycles and clear on leaving STALL.
REQ-030 When the stall-run counter reaches STALL_LIMIT, deadlock_err SHALL set and hold until reset.
REQ-031 stall_cnt and the stall-run counter SHALL NOT count stalls that occur in FLUSH.
REQ-032 With instv=0, issue and stall SHALL both be 0, and counters change only by write-back.

Reset
REQ-033 Reset SHALL clear, asynchronously, all pend, busy_map, stall_cnt, the stall-run counter and deadlock_err, and SHALL force the FSM to FLUSH.
REQ-034 issue SHALL be 0 while reset is high; stall SHALL equal instv while reset is high.
REQ-035 Reset mid-operation SHALL discard all in-flight pending state; write-backs arriving after reset SHALL be treated per REQ-026.

Verification
REQ-036 Scenario 1: reset, then instv=1 for cycles 0-3 -> stall=1, issue=0 in cycles 0-1; issue=1 from cycle 2; stall_cnt=0.
REQ-037 Scenario 2: issue wr_en dst=3; next cycle src1=3 src1_rd=1 -> stall=1, busy_map=0x08; wb_dst=3 -> issue one cycle after the write-back.
REQ-038 Scenario 3: three issues to dst=5, fourth wr_en dst=5 -> pend[5]=3 and the fourth instruction stalls; one wb_dst=5 -> it issues.
REQ-039 Scenario 4: issue wr_en dst=2 with wb_wr_en wb_dst=2 in the same cycle while pend[2]=1 -> pend[2] stays 1.
REQ-040 Scenario 5: hold a hazard with no write-back -> deadlock_err=1 after 15 STALL cycles; it stays 1 after the hazard clears; reset clears it.
REQ-041 Scenario 6: force 70000 stall cycles -> stall_cnt=0xFFFF and holds.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Issue-stage register hazard scoreboard: per-register pending write counters,
// issue/stall decision, stall statistics and a sticky deadlock watchdog.
`timescale 1ns/1ps

//  state | meaning
//  FLUSH | post-reset settle window (2 cycles); nothing issues
//  RUN   | normal issue; presented instruction issues unless hazarded
//  STALL | previous cycle stalled; instruction is being re-presented
module hazard_scoreboard #(
    parameter int NREG        = 8,
    parameter int AW          = 3,
    parameter int STALL_LIMIT = 15
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            instv,
    input  logic [AW-1:0]   src1,
    input  logic [AW-1:0]   src2,
    input  logic            src1_rd,
    input  logic            src2_rd,
    input  logic [AW-1:0]   dst,
    input  logic            wr_en,
    input  logic            wb_wr_en,
    input  logic [AW-1:0]   wb_dst,
    output logic            issue,
    output logic            stall,
    output logic [NREG-1:0] busy_map,
    output logic [15:0]     stall_cnt,
    output logic            deadlock_err
);

    typedef enum logic [1:0] {
        FLUSH = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2
    } state_t;

    localparam int RW = $clog2(STALL_LIMIT + 1);
    localparam logic [RW-1:0] RUN_MAX = RW'(STALL_LIMIT);

    state_t               state;
    state_t               state_nxt;
    logic                 flush_cnt;
    logic [NREG-1:0][1:0] pend;
    logic [NREG-1:0]      inc_hit;
    logic [NREG-1:0]      wb_hit;
    logic                 hazard;
    logic                 stall_counted;
    logic [RW-1:0]        run_cnt;
    logic [RW-1:0]        run_nxt;

    // Hazards look only at registered counters; a write-back this cycle
    // releases the consumer on the following cycle.
    always_comb begin
        hazard = (src1_rd && (pend[src1] != 2'd0))
               | (src2_rd && (pend[src2] != 2'd0))
               | (wr_en   && (pend[dst]  == 2'd3));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= FLUSH;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        issue     = 1'b0;
        stall     = 1'b0;
        state_nxt = state;
        case (state)
            FLUSH: begin
                stall = instv;
                if (flush_cnt == 1'b0) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                issue = instv & ~hazard;
                stall = instv & hazard;
                if (stall) begin
                    state_nxt = STALL;
                end
            end
            STALL: begin
                issue = instv & ~hazard;
                stall = instv & hazard;
                if (!stall) begin
                    state_nxt = RUN;
                end
            end
            default: begin
                stall     = instv;
                state_nxt = FLUSH;
            end
        endcase
        if (reset) begin
            issue = 1'b0;
            stall = instv;
        end
    end

    // FLUSH window timer: loaded whenever outside FLUSH, counts down inside it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            flush_cnt <= 1'b1;
        end else if (state != FLUSH) begin
            flush_cnt <= 1'b1;
        end else if (flush_cnt != 1'b0) begin
            flush_cnt <= flush_cnt - 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            inc_hit[i] = issue && wr_en && (dst == AW'(i));
            wb_hit[i]  = wb_wr_en && (wb_dst == AW'(i));
            busy_map[i] = (pend[i] != 2'd0);
        end
    end

    // Simultaneous issue and write-back to one register cancel out.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pend <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (inc_hit[i] && !wb_hit[i]) begin
                    if (pend[i] != 2'd3) begin
                        pend[i] <= pend[i] + 2'd1;
                    end
                end else if (wb_hit[i] && !inc_hit[i]) begin
                    if (pend[i] != 2'd0) begin
                        pend[i] <= pend[i] - 2'd1;
                    end
                end
            end
        end
    end

    assign stall_counted = stall && (state != FLUSH);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (stall_counted && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

    always_comb begin
        run_nxt = '0;
        if ((state == STALL) && stall) begin
            run_nxt = (run_cnt == RUN_MAX) ? run_cnt : run_cnt + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            run_cnt      <= '0;
            deadlock_err <= 1'b0;
        end else begin
            run_cnt <= run_nxt;
            if (run_nxt == RUN_MAX) begin
                deadlock_err <= 1'b1;
            end
        end
    end

endmodule
